// File: rtl/psum_buffer.sv
// Partial-sum accumulation buffer: accumulates PE-array partial sums into a local store
// and, on the last pass, queues the ReLU/shift/saturated vector and streams it out element-wise.
module psum_buffer #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 24,
  parameter int LANES  = 8,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int OUT_W  = 8,
  parameter int SHIFT  = 8,
  parameter int QDEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    psumEn,
  input  logic                    first,
  input  logic                    last,
  input  logic [ADDR_W-1:0]       headAddress,
  input  logic [LANES*DATA_W-1:0] psumIn,
  output logic [OUT_W-1:0]        outData,
  output logic                    outValid,
  input  logic                    outReady,
  output logic                    outLast,
  output logic                    busy,
  output logic                    overflow
);

  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int QA_W   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W  = $clog2(QDEPTH + 1);
  localparam int VEC_W  = LANES * OUT_W;
  localparam logic [ACC_W-1:0] OUT_MAX = ACC_W'((64'd1 << OUT_W) - 64'd1);

  typedef enum logic {IDLE, SEND} state_t;

  function automatic logic [OUT_W-1:0] relu_shift_sat(input logic signed [ACC_W-1:0] v);
    logic [ACC_W-1:0] r;
    logic [ACC_W-1:0] s;
    r = v[ACC_W-1] ? '0 : v;
    s = r >> SHIFT;
    return (s > OUT_MAX) ? {OUT_W{1'b1}} : s[OUT_W-1:0];
  endfunction

  function automatic logic [OUT_W-1:0] lane_sel(input logic [VEC_W-1:0] v,
                                                input logic [LANE_W-1:0] l);
    return v[int'(l)*OUT_W +: OUT_W];
  endfunction

  function automatic logic [QA_W-1:0] qnext(input logic [QA_W-1:0] p);
    return (int'(p) == QDEPTH - 1) ? '0 : p + QA_W'(1);
  endfunction

  logic signed [ACC_W-1:0] mem_q [DEPTH];
  logic signed [ACC_W-1:0] mem_d [DEPTH];
  logic [VEC_W-1:0]        fifo_q [QDEPTH];
  logic [VEC_W-1:0]        fifo_d [QDEPTH];
  logic [QA_W-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt;
  logic [CNT_W-1:0]        count_q, count_d;
  state_t                  state_q, state_d;
  logic [LANE_W-1:0]       lane_q, lane_d, lane_inc;
  logic [OUT_W-1:0]        out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic                    overflow_q, overflow_d;

  logic [ADDR_W-1:0]       lane_addr [LANES];
  logic signed [ACC_W-1:0] lane_sum  [LANES];
  logic [VEC_W-1:0]        push_vec;
  logic                    xfer, pop, push_req, push;

  // Accumulate stage: sums are computed from the current store and also feed the queue directly
  always_comb begin
    mem_d    = mem_q;
    push_vec = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_addr[i] = headAddress + ADDR_W'(i);
      lane_sum[i]  = first ? ACC_W'($signed(psumIn[i*DATA_W +: DATA_W]))
                           : mem_q[lane_addr[i]] + ACC_W'($signed(psumIn[i*DATA_W +: DATA_W]));
      if (psumEn) mem_d[lane_addr[i]] = lane_sum[i];
      push_vec[i*OUT_W +: OUT_W] = relu_shift_sat(lane_sum[i]);
    end
  end

  // Staging queue and drain control; a full queue still accepts a push on a pop edge
  always_comb begin
    xfer       = out_valid_q && outReady;
    pop        = xfer && (lane_q == LANE_W'(LANES - 1));
    push_req   = psumEn && last;
    push       = push_req && ((count_q != CNT_W'(QDEPTH)) || pop);
    overflow_d = overflow_q | (push_req && !push);
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_d   = push ? qnext(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop ? qnext(rd_ptr_q) : rd_ptr_q;
    rd_nxt     = qnext(rd_ptr_q);
    lane_inc   = lane_q + LANE_W'(1);
    fifo_d     = fifo_q;
    if (push) fifo_d[wr_ptr_q] = push_vec;

    state_d     = state_q;
    lane_d      = lane_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d     = SEND;
          lane_d      = '0;
          out_valid_d = 1'b1;
          out_last_d  = (LANES == 1);
          out_data_d  = lane_sel(fifo_q[rd_ptr_q], '0);
        end
      end
      SEND: begin
        if (pop) begin
          lane_d = '0;
          if (count_q > CNT_W'(1)) begin
            out_data_d = lane_sel(fifo_q[rd_nxt], '0);
            out_last_d = (LANES == 1);
          end else if (push) begin
            // Queue would be empty but for the vector arriving now: forward it, no bubble
            out_data_d = lane_sel(push_vec, '0);
            out_last_d = (LANES == 1);
          end else begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end
        end else if (xfer) begin
          lane_d     = lane_inc;
          out_data_d = lane_sel(fifo_q[rd_ptr_q], lane_inc);
          out_last_d = (lane_inc == LANE_W'(LANES - 1));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      for (int i = 0; i < QDEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= IDLE;
      lane_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      lane_q      <= lane_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      overflow_q  <= overflow_d;
    end
  end

  assign outData  = out_data_q;
  assign outValid = out_valid_q;
  assign outLast  = out_last_q;
  assign overflow = overflow_q;
  assign busy     = (count_q != '0) || out_valid_q;

endmodule
